// File: rtl/packet_source.sv
// Packet source driving a 4-phase req/ack handshake.
// Emits NUM_PKTS packets per run, separated by GAP idle cycles.
module packet_source #(
    parameter int NODE         = 0,
    parameter int WIDTH_packet = 14,
    parameter int ADDR_W       = 4,
    parameter int NUM_PKTS     = 8,
    parameter int GAP          = 2,
    parameter int DEST_START   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    ack,
    output logic                    req,
    output logic [WIDTH_packet-1:0] data,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              sent_cnt
);

    localparam int                PAY_W = WIDTH_packet - 2 * ADDR_W;
    localparam logic [7:0]        NUM_C = 8'(NUM_PKTS);
    localparam logic [3:0]        GAP_C = 4'(GAP);
    localparam logic [ADDR_W-1:0] SRC_C = ADDR_W'(NODE);
    localparam logic [ADDR_W-1:0] DST_C = ADDR_W'(DEST_START);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_REQ_HI      = 3'd1,
        S_WAIT_ACK_LO = 3'd2,
        S_GAP_WAIT    = 3'd3,
        S_DONE        = 3'd4
    } state_t;

    // Packet k: dest wraps modulo 2^ADDR_W, payload is k truncated to the payload width.
    function automatic logic [WIDTH_packet-1:0] build_pkt(input logic [7:0] k);
        logic [ADDR_W-1:0] dest;
        dest = DST_C + ADDR_W'(k);
        return {dest, SRC_C, PAY_W'(k)};
    endfunction

    state_t                  r_state;
    logic                    r_req;
    logic [WIDTH_packet-1:0] r_data;
    logic                    r_busy;
    logic                    r_done;
    logic [7:0]              r_sent_cnt;
    logic [3:0]              r_gap_cnt;

    state_t                  w_state_nxt;
    logic [7:0]              w_cnt_nxt;
    logic [3:0]              w_gap_nxt;
    logic                    w_load_pkt;

    // Next-state, sent counter and gap counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_sent_cnt;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_cnt_nxt = 8'd0;
                    w_gap_nxt = 4'd0;
                    if (NUM_C == 8'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_REQ_HI;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_REQ_HI: begin
                if (ack) begin
                    w_state_nxt = S_WAIT_ACK_LO;
                    w_cnt_nxt   = r_sent_cnt + 8'd1;
                end else begin
                    w_state_nxt = S_REQ_HI;
                end
            end
            S_WAIT_ACK_LO: begin
                // Only a sampled ack=0 may lead back to REQ_HI, so a lingering ack never double-counts.
                if (!ack) begin
                    if (r_sent_cnt == NUM_C) begin
                        w_state_nxt = S_DONE;
                    end else if (GAP_C != 4'd0) begin
                        w_state_nxt = S_GAP_WAIT;
                        w_gap_nxt   = GAP_C;
                    end else begin
                        w_state_nxt = S_REQ_HI;
                    end
                end else begin
                    w_state_nxt = S_WAIT_ACK_LO;
                end
            end
            S_GAP_WAIT: begin
                if (r_gap_cnt <= 4'd1) begin
                    w_state_nxt = S_REQ_HI;
                    w_gap_nxt   = 4'd0;
                end else begin
                    w_gap_nxt   = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
                w_gap_nxt   = 4'd0;
            end
        endcase
        w_load_pkt = (w_state_nxt == S_REQ_HI) && (r_state != S_REQ_HI);
    end

    // State and registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sent_cnt <= 8'd0;
            r_gap_cnt  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_sent_cnt <= w_cnt_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_req      <= (w_state_nxt == S_REQ_HI);
            r_busy     <= (w_state_nxt == S_REQ_HI) || (w_state_nxt == S_WAIT_ACK_LO) ||
                          (w_state_nxt == S_GAP_WAIT);
            r_done     <= (w_state_nxt == S_DONE);
            if (w_load_pkt) begin
                r_data <= build_pkt(w_cnt_nxt);
            end
        end
    end

    assign req      = r_req;
    assign data     = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_packet_source.sv
// Directed self-checking bench for packet_source, using four differently parameterised instances.
module tb_packet_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, start1, start2, start3;
    logic ack_man;
    logic rx_mode;
    int   total = 0;
    int   bad   = 0;

    logic        req0, req1, req2, req3;
    logic [13:0] data0, data1, data2, data3;
    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic [7:0]  sent0, sent1, sent2, sent3;
    logic        ack0, ack1, ack2, ack3;
    logic        r_prev0, r_prev2;

    // Receivers: delayed (ack follows req one cycle late), ideal combinational, or manual.
    always @(posedge clk) begin
        r_prev0 <= req0;
        r_prev2 <= req2;
    end
    assign ack0 = rx_mode ? r_prev0 : ack_man;
    assign ack1 = req1;
    assign ack2 = r_prev2;
    assign ack3 = ack_man;

    packet_source u0 (
        .clk(clk), .rst(rst), .start(start0), .ack(ack0), .req(req0), .data(data0),
        .busy(busy0), .done(done0), .sent_cnt(sent0)
    );
    packet_source #(.GAP(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .ack(ack1), .req(req1), .data(data1),
        .busy(busy1), .done(done1), .sent_cnt(sent1)
    );
    packet_source #(.NODE(5), .NUM_PKTS(4), .GAP(1), .DEST_START(14)) u2 (
        .clk(clk), .rst(rst), .start(start2), .ack(ack2), .req(req2), .data(data2),
        .busy(busy2), .done(done2), .sent_cnt(sent2)
    );
    packet_source #(.NUM_PKTS(0)) u3 (
        .clk(clk), .rst(rst), .start(start3), .ack(ack3), .req(req3), .data(data3),
        .busy(busy3), .done(done3), .sent_cnt(sent3)
    );

    // Default packets: {dest=k+1, src=0, payload=k}
    logic [13:0] exp_def [8] = '{14'h0400, 14'h0801, 14'h0C02, 14'h1003,
                                 14'h1404, 14'h1805, 14'h1C06, 14'h2007};
    logic [3:0]  exp_dest2 [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (req0 !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", req0); end
        total++; if (data0 !== 14'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", data0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy0); end
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", done0); end
        total++; if (sent0 !== 8'd0) begin bad++; $display("FAIL reset_sent got=%0d exp=0", sent0); end
        total++; if (done3 !== 1'b0) begin bad++; $display("FAIL reset_done3 got=%0h exp=0", done3); end
        rst = 1'b0;
    endtask

    task automatic test_default_run();
        int n;
        int cyc;
        logic prev;
        n = 0; cyc = 0; prev = 1'b0;
        rx_mode = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++; if (req0 !== 1'b1) begin bad++; $display("FAIL def_first_req got=%0h exp=1", req0); end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL def_busy got=%0h exp=1", busy0); end
        while (done0 !== 1'b1 && cyc < 300) begin
            if (req0 && !prev) begin
                if (n < 8) begin
                    total++;
                    if (data0 !== exp_def[n]) begin
                        bad++; $display("FAIL def_data[%0d] got=%0h exp=%0h", n, data0, exp_def[n]);
                    end
                    total++;
                    if (sent0 !== 8'(n)) begin
                        bad++; $display("FAIL def_sent_at_req[%0d] got=%0d exp=%0d", n, sent0, n);
                    end
                end
                n++;
            end
            prev = req0;
            tick();
            cyc++;
        end
        total++; if (cyc >= 300) begin bad++; $display("FAIL def_timeout got=%0d exp=<300", cyc); end
        total++; if (n != 8) begin bad++; $display("FAIL def_pkt_count got=%0d exp=8", n); end
        total++; if (sent0 !== 8'd8) begin bad++; $display("FAIL def_final_sent got=%0d exp=8", sent0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL def_final_busy got=%0h exp=0", busy0); end
        total++; if (req0 !== 1'b0) begin bad++; $display("FAIL def_final_req got=%0h exp=0", req0); end
    endtask

    task automatic test_ack_ignored();
        rx_mode = 1'b0;
        ack_man = 1'b1;
        repeat (3) tick();
        total++; if (sent0 !== 8'd8) begin bad++; $display("FAIL ackdone_sent got=%0d exp=8", sent0); end
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL ackdone_done got=%0h exp=1", done0); end
        total++; if (req0 !== 1'b0) begin bad++; $display("FAIL ackdone_req got=%0h exp=0", req0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        total++; if (req0 !== 1'b0) begin bad++; $display("FAIL ackidle_req got=%0h exp=0", req0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL ackidle_busy got=%0h exp=0", busy0); end
        total++; if (sent0 !== 8'd0) begin bad++; $display("FAIL ackidle_sent got=%0d exp=0", sent0); end
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL ackidle_done got=%0h exp=0", done0); end
        ack_man = 1'b0;
    endtask

    // t counts cycles from the first req (t=0); req every 2 cycles, sent_cnt=8 at t=15 (16th cycle).
    task automatic test_gap0();
        logic       exp_req;
        logic [7:0] exp_sent;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int t = 0; t <= 16; t++) begin
            exp_req  = (t < 16) && ((t % 2) == 0);
            exp_sent = 8'((t + 1) / 2);
            total++;
            if (req1 !== exp_req) begin
                bad++; $display("FAIL gap0_req[t=%0d] got=%0h exp=%0h", t, req1, exp_req);
            end
            total++;
            if (sent1 !== exp_sent) begin
                bad++; $display("FAIL gap0_sent[t=%0d] got=%0d exp=%0d", t, sent1, exp_sent);
            end
            if (t < 16) tick();
        end
        total++; if (done1 !== 1'b1) begin bad++; $display("FAIL gap0_done got=%0h exp=1", done1); end
    endtask

    task automatic test_dest_wrap();
        int n;
        int cyc;
        logic prev;
        n = 0; cyc = 0; prev = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        while (done2 !== 1'b1 && cyc < 200) begin
            if (req2 && !prev) begin
                if (n < 4) begin
                    total++;
                    if (data2[13:10] !== exp_dest2[n]) begin
                        bad++; $display("FAIL wrap_dest[%0d] got=%0d exp=%0d", n, data2[13:10], exp_dest2[n]);
                    end
                    total++;
                    if (data2[9:6] !== 4'd5) begin
                        bad++; $display("FAIL wrap_src[%0d] got=%0d exp=5", n, data2[9:6]);
                    end
                    total++;
                    if (data2[5:0] !== 6'(n)) begin
                        bad++; $display("FAIL wrap_payload[%0d] got=%0d exp=%0d", n, data2[5:0], n);
                    end
                end
                n++;
            end
            prev = req2;
            tick();
            cyc++;
        end
        total++; if (cyc >= 200) begin bad++; $display("FAIL wrap_timeout got=%0d exp=<200", cyc); end
        total++; if (n != 4) begin bad++; $display("FAIL wrap_pkt_count got=%0d exp=4", n); end
        total++; if (sent2 !== 8'd4) begin bad++; $display("FAIL wrap_sent got=%0d exp=4", sent2); end
    endtask

    task automatic test_start_in_gap();
        int n;
        int cyc;
        int mark;
        logic prev;
        n = 0; cyc = 0; mark = -1; prev = 1'b0;
        rx_mode = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        while (done0 !== 1'b1 && cyc < 300) begin
            if (req0 && !prev) begin
                if (n < 8) begin
                    total++;
                    if (data0 !== exp_def[n]) begin
                        bad++; $display("FAIL gapstart_data[%0d] got=%0h exp=%0h", n, data0, exp_def[n]);
                    end
                end
                n++;
            end
            if (mark < 0 && sent0 == 8'd1) mark = cyc;
            // Two cycles after the first count the FSM sits in GAP_WAIT (busy, req low).
            if (mark >= 0 && cyc == mark + 2) begin
                total++;
                if (busy0 !== 1'b1 || req0 !== 1'b0) begin
                    bad++; $display("FAIL gapstart_in_gap got=busy%0h/req%0h exp=busy1/req0", busy0, req0);
                end
                start0 = 1'b1;
            end else begin
                start0 = 1'b0;
            end
            prev = req0;
            tick();
            cyc++;
        end
        start0 = 1'b0;
        total++; if (cyc >= 300) begin bad++; $display("FAIL gapstart_timeout got=%0d exp=<300", cyc); end
        total++; if (n != 8) begin bad++; $display("FAIL gapstart_pkt_count got=%0d exp=8", n); end
        total++; if (sent0 !== 8'd8) begin bad++; $display("FAIL gapstart_sent got=%0d exp=8", sent0); end
    endtask

    task automatic test_restart();
        rx_mode = 1'b0;
        ack_man = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++; if (req0 !== 1'b1) begin bad++; $display("FAIL restart_req got=%0h exp=1", req0); end
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL restart_done got=%0h exp=0", done0); end
        total++; if (sent0 !== 8'd0) begin bad++; $display("FAIL restart_sent got=%0d exp=0", sent0); end
        total++; if (data0 !== exp_def[0]) begin bad++; $display("FAIL restart_data got=%0h exp=%0h", data0, exp_def[0]); end
    endtask

    task automatic test_reset_mid();
        int rises;
        rises = 0;
        repeat (5) tick();
        total++; if (req0 !== 1'b1) begin bad++; $display("FAIL mid_req_held got=%0h exp=1", req0); end
        total++; if (sent0 !== 8'd0) begin bad++; $display("FAIL mid_sent_held got=%0d exp=0", sent0); end
        rst = 1'b1;
        ack_man = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (req0 !== 1'b0) begin bad++; $display("FAIL mid_req got=%0h exp=0", req0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0h exp=0", busy0); end
        total++; if (sent0 !== 8'd0) begin bad++; $display("FAIL mid_sent got=%0d exp=0", sent0); end
        ack_man = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req0 === 1'b1) rises++;
        end
        total++; if (rises != 0) begin bad++; $display("FAIL mid_no_req got=%0d exp=0", rises); end
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++; if (req0 !== 1'b1) begin bad++; $display("FAIL mid_new_start got=%0h exp=1", req0); end
    endtask

    task automatic test_zero_pkts();
        int rises;
        rises = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        total++; if (done3 !== 1'b1) begin bad++; $display("FAIL zero_done got=%0h exp=1", done3); end
        total++; if (req3 !== 1'b0) begin bad++; $display("FAIL zero_req got=%0h exp=0", req3); end
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL zero_busy got=%0h exp=0", busy3); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req3 === 1'b1) rises++;
        end
        total++; if (rises != 0) begin bad++; $display("FAIL zero_no_req got=%0d exp=0", rises); end
    endtask

    initial begin
        rst     = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        start3  = 1'b0;
        ack_man = 1'b0;
        rx_mode = 1'b0;
        test_reset();
        test_default_run();
        test_ack_ignored();
        test_gap0();
        test_dest_wrap();
        test_start_in_gap();
        test_restart();
        test_reset_mid();
        test_zero_pkts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
